pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 PC_SEL  input  1  redirect select from the branch logic unit; 1 = take PC_TARGET.
REQ-005 CTRL_BRANCH  input  2  control-flow class: 00 none, 01 JAL, 10 JALR, 11 SB.
REQ-006 PC_TARGET  input  32  redirect target address.
REQ-007 STALL  input  1  decode/execute not ready; holds the current instruction.
REQ-008 IMEM_REQ  output  1  instruction memory read request.
REQ-009 IMEM_ADDR  output  32  instruction memory word address (byte-addressed, 4-aligned).
REQ-010 IMEM_ACK  input  1  read complete; IMEM_RDATA valid this cycle.
REQ-011 IMEM_RDATA  input  32  fetched instruction word.
REQ-012 INSTR  output  32  current instruction to decode.
REQ-013 INSTR_PC  output  32  address of INSTR.
REQ-014 PC_PLUS4  output  32  INSTR_PC + 4, for JAL/JALR link value.
REQ-015 INSTR_VALID  output  1  INSTR/INSTR_PC hold a fetched, unconsumed instruction.
REQ-016 MISALIGN  output  1  sticky flag: redirect target not 4-aligned.
REQ-017 RETIRE_CNT  output  32  count of consumed instructions.

Function
REQ-018 FSM states SHALL be S_BOOT, S_FETCH, S_HOLD, S_TRAP.
REQ-019 S_BOOT: entered on reset; unconditionally goes to S_FETCH in the first clock after reset deassertion.
REQ-020 S_FETCH: IMEM_REQ=1, IMEM_ADDR=PC; IMEM_ADDR SHALL stay stable until IMEM_ACK is sampled high.
REQ-021 On IMEM_ACK in S_FETCH, the unit SHALL register INSTR=IMEM_RDATA and INSTR_PC=PC, move to S_HOLD, and set INSTR_VALID=1 in the next cycle; minimum fetch latency is one cycle of IMEM_REQ.
REQ-022 S_HOLD: IMEM_REQ=0; INSTR, INSTR_PC and INSTR_VALID SHALL hold while STALL=1.
REQ-023 Consumption occurs on a cycle with INSTR_VALID=1 and STALL=0. RETIRE_CNT SHALL increment by 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-024 Next PC on consumption: PC_SEL=0 -> INSTR_PC+4; PC_SEL=1 -> PC_TARGET, with bit 0 cleared when CTRL_BRANCH=10 (JALR).
REQ-025 After consumption, INSTR_VALID SHALL drop and the FSM SHALL return to S_FETCH with the new PC; a consumed instruction SHALL never be presented twice.
REQ-026 PC_SEL, CTRL_BRANCH and PC_TARGET SHALL be ignored in every cycle except a consumption cycle.
REQ-027 If a redirect target has nonzero bits [1:0] after the JALR mask, the unit SHALL enter S_TRAP and set MISALIGN=1. In S_TRAP, IMEM_REQ=0, INSTR_VALID=0 and PC is frozen until reset.
REQ-028 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0) without error.
REQ-029 IMEM_ACK outside S_FETCH SHALL be ignored.
REQ-030 PC_PLUS4 SHALL be combinational from INSTR_PC.

Reset
REQ-031 On RST=1, regardless of clock, the unit SHALL set the following immediately: PC=RESET_PC, INSTR=32'h0000_0013 (NOP), INSTR_PC=RESET_PC, INSTR_VALID=0, IMEM_REQ=0, MISALIGN=0, RETIRE_CNT=0, state=S_BOOT.
REQ-032 Reset during an outstanding fetch SHALL drop IMEM_REQ at once; an IMEM_ACK arriving while RST=1 or in S_BOOT SHALL be discarded.

Structure
REQ-033 Shared package pc_fetch_pkg SHALL hold the FSM state enum, NOP_INSTR constant and CTRL_BRANCH encodings (BR_NONE, BR_JAL, BR_JALR, BR_SB), shared with the branch logic unit.
REQ-034 Next-PC selection, JALR masking and misalignment detection SHALL be one combinational sub-module named pc_next_calc; all registers and the FSM stay in pc_fetch_unit.

Verification
REQ-035 Reset release, RESET_PC=0, ack after 2 wait cycles -> IMEM_ADDR=0 held 3 cycles, then INSTR_VALID=1 with INSTR=IMEM_RDATA and INSTR_PC=0.
REQ-036 Sequential flow, STALL=0, PC_SEL=0, single-cycle ack -> addresses 0,4,8; RETIRE_CNT=3 after third consumption.
REQ-037 STALL=1 for 4 cycles in S_HOLD, with PC_SEL=1 and PC_TARGET=0x100 pulsed during the stall -> no fetch, INSTR unchanged, pulse ignored; the next fetch after release is INSTR_PC+4.
REQ-038 JALR consumption with PC_TARGET=0x0000_0201 -> next IMEM_ADDR=0x200, MISALIGN=0; SB with PC_TARGET=0x202 -> MISALIGN=1, IMEM_REQ=0 until RST.
REQ-039 RST pulsed while IMEM_REQ=1 at address 0x40, with ack arriving during reset -> IMEM_REQ drops asynchronously, ack is discarded, and fetch restarts at RESET_PC.
REQ-040 INSTR_PC=0xFFFF_FFFC consumed with PC_SEL=0 -> next IMEM_ADDR=0, PC_PLUS4=0, no MISALIGN.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the reset instruction, and the
// control-flow class codes that the branch logic unit drives.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_TRAP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_JAL  = 2'b01;
    localparam logic [1:0] BR_JALR = 2'b10;
    localparam logic [1:0] BR_SB   = 2'b11;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction memory read port: the fetch unit is the master, the memory the slave.
interface pc_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential step, redirect with JALR bit-0 masking,
// and detection of a redirect that is not word aligned.
module pc_next_calc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] instr_pc_i,
    input  logic        pc_sel_i,
    input  logic [1:0]  ctrl_branch_i,
    input  logic [31:0] pc_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] target_masked;

    always_comb begin
        target_masked = pc_target_i;
        if (ctrl_branch_i == BR_JALR) begin
            target_masked[0] = 1'b0;
        end
    end

    // Wraps naturally modulo 2^32, so 0xFFFF_FFFC steps to 0.
    assign pc_plus4_o = instr_pc_i + 32'd4;

    assign next_pc_o  = pc_sel_i ? target_masked : pc_plus4_o;

    // The sequential path is always aligned; only a redirect can misalign.
    assign misalign_o = pc_sel_i && !is_word_aligned(target_masked);

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch stage: fetches at PC, holds the word until decode
// consumes it, then steps or redirects. A misaligned redirect parks the unit until reset.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    pc_fetch_unit_if.master         imem,
    input  logic                    pc_sel_i,
    input  logic [1:0]              ctrl_branch_i,
    input  logic [31:0]             pc_target_i,
    input  logic                    stall_i,
    output logic [31:0]             instr_o,
    output logic [31:0]             instr_pc_o,
    output logic [31:0]             pc_plus4_o,
    output logic                    instr_valid_o,
    output logic                    misalign_o,
    output logic [31:0]             retire_cnt_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  retire_cnt_q, retire_cnt_d;

    logic         imem_req;
    logic [31:0]  calc_next_pc;
    logic         calc_misalign;

    pc_next_calc u_pc_next_calc (
        .instr_pc_i    (instr_pc_q),
        .pc_sel_i      (pc_sel_i),
        .ctrl_branch_i (ctrl_branch_i),
        .pc_target_i   (pc_target_i),
        .pc_plus4_o    (pc_plus4_o),
        .next_pc_o     (calc_next_pc),
        .misalign_o    (calc_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= RESET_PC;
            misalign_q   <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            misalign_q   <= misalign_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Branch-unit inputs and the memory ack only matter in the one state that uses them.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        misalign_d   = misalign_q;
        retire_cnt_d = retire_cnt_q;
        imem_req     = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem.ack) begin
                    instr_d    = imem.rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    retire_cnt_d = retire_cnt_q + 32'd1;
                    if (calc_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = S_TRAP;
                    end else begin
                        pc_d    = calc_next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Request is decoded from the state register so an asynchronous reset drops it at once.
    assign imem.req      = imem_req;
    assign imem.addr     = pc_q;

    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = (state_q == S_HOLD);
    assign misalign_o    = misalign_q;
    assign retire_cnt_o  = retire_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequential flow, stall, JALR/SB redirects,
// reset during an outstanding fetch and PC wrap.
module tb_pc_fetch_unit;
    import pc_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_sel;
    logic [1:0]  ctrl_branch;
    logic [31:0] pc_target;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_retire = 32'd0;

    pc_fetch_unit_if imem_if ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem_if),
        .pc_sel_i      (pc_sel),
        .ctrl_branch_i (ctrl_branch),
        .pc_target_i   (pc_target),
        .stall_i       (stall),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .pc_plus4_o    (pc_plus4),
        .instr_valid_o (instr_valid),
        .misalign_o    (misalign),
        .retire_cnt_o  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in S_FETCH; holds ack low for 'waits' cycles, then returns one word.
    task automatic fetch_word(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input int waits);
        for (int i = 0; i < waits; i++) begin
            check_eq({tag, " req"}, {31'd0, imem_if.req}, 32'd1);
            check_eq({tag, " addr"}, imem_if.addr, addr);
            tick();
        end
        check_eq({tag, " req"}, {31'd0, imem_if.req}, 32'd1);
        check_eq({tag, " addr"}, imem_if.addr, addr);
        imem_if.ack   = 1'b1;
        imem_if.rdata = data;
        tick();
        imem_if.ack   = 1'b0;
        imem_if.rdata = 32'hDEAD_BEEF;
        check_eq({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
        check_eq({tag, " instr"}, instr, data);
        check_eq({tag, " instr_pc"}, instr_pc, addr);
        check_eq({tag, " hold req"}, {31'd0, imem_if.req}, 32'd0);
    endtask

    // Entered in S_HOLD with stall low; consumes with the given branch-unit inputs.
    task automatic consume(input string tag, input logic sel, input logic [1:0] br,
                           input logic [31:0] tgt);
        pc_sel      = sel;
        ctrl_branch = br;
        pc_target   = tgt;
        tick();
        pc_sel      = 1'b0;
        ctrl_branch = BR_NONE;
        pc_target   = 32'd0;
        exp_retire  = exp_retire + 32'd1;
        check_eq({tag, " retire"}, retire_cnt, exp_retire);
        check_eq({tag, " valid drop"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        pc_sel        = 1'b0;
        ctrl_branch   = BR_NONE;
        pc_target     = 32'd0;
        stall         = 1'b0;
        imem_if.ack   = 1'b0;
        imem_if.rdata = 32'd0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check_eq("rst req", {31'd0, imem_if.req}, 32'd0);
        check_eq("rst instr", instr, NOP_INSTR);
        check_eq("rst instr_pc", instr_pc, 32'd0);
        check_eq("rst valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst misalign", {31'd0, misalign}, 32'd0);
        check_eq("rst retire", retire_cnt, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("boot req", {31'd0, imem_if.req}, 32'd0);
        tick();

        // Two wait cycles on the first fetch, then sequential single-cycle fetches
        fetch_word("f0", 32'h0, 32'h1111_0001, 2);
        check_eq("f0 pc_plus4", pc_plus4, 32'h4);
        consume("c0", 1'b0, BR_NONE, 32'd0);
        fetch_word("f4", 32'h4, 32'h1111_0002, 0);
        consume("c4", 1'b0, BR_NONE, 32'd0);
        fetch_word("f8", 32'h8, 32'h1111_0003, 0);
        consume("c8", 1'b0, BR_NONE, 32'd0);
        check_eq("three retired", retire_cnt, 32'd3);

        // Stall in hold with a redirect pulse and a stray ack, both ignored
        stall = 1'b1;
        fetch_word("f12", 32'hC, 32'h2222_0004, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                pc_sel        = 1'b1;
                ctrl_branch   = BR_JAL;
                pc_target     = 32'h100;
                imem_if.ack   = 1'b1;
                imem_if.rdata = 32'h5555_5555;
            end else begin
                pc_sel        = 1'b0;
                ctrl_branch   = BR_NONE;
                pc_target     = 32'd0;
                imem_if.ack   = 1'b0;
            end
            tick();
            check_eq("stall req", {31'd0, imem_if.req}, 32'd0);
            check_eq("stall valid", {31'd0, instr_valid}, 32'd1);
            check_eq("stall instr", instr, 32'h2222_0004);
            check_eq("stall retire", retire_cnt, 32'd3);
        end
        imem_if.ack = 1'b0;
        stall = 1'b0;
        consume("c12", 1'b0, BR_NONE, 32'd0);

        // JALR clears bit 0; SB to a misaligned target traps
        fetch_word("f16", 32'h10, 32'h3333_0005, 0);
        consume("jalr", 1'b1, BR_JALR, 32'h0000_0201);
        check_eq("jalr misalign", {31'd0, misalign}, 32'd0);
        fetch_word("f200", 32'h200, 32'h3333_0006, 0);
        consume("sb", 1'b1, BR_SB, 32'h0000_0202);
        check_eq("trap misalign", {31'd0, misalign}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            imem_if.ack = (k == 1);
            tick();
            check_eq("trap req", {31'd0, imem_if.req}, 32'd0);
            check_eq("trap valid", {31'd0, instr_valid}, 32'd0);
            check_eq("trap misalign sticky", {31'd0, misalign}, 32'd1);
        end
        imem_if.ack = 1'b0;

        // Reset clears the trap
        rst = 1'b1;
        #1;
        check_eq("trap rst misalign", {31'd0, misalign}, 32'd0);
        check_eq("trap rst retire", retire_cnt, 32'd0);
        exp_retire = 32'd0;
        tick();
        rst = 1'b0;
        tick();

        // Jump to 0x40, then reset mid-fetch with an ack arriving during reset
        fetch_word("r0", 32'h0, 32'h4444_0001, 0);
        consume("jal40", 1'b1, BR_JAL, 32'h40);
        check_eq("f40 req", {31'd0, imem_if.req}, 32'd1);
        check_eq("f40 addr", imem_if.addr, 32'h40);
        #3 rst = 1'b1;
        #1;
        check_eq("async req drop", {31'd0, imem_if.req}, 32'd0);
        imem_if.ack   = 1'b1;
        imem_if.rdata = 32'hBAD0_BAD0;
        tick();
        rst = 1'b0;
        exp_retire = 32'd0;
        tick();
        imem_if.ack = 1'b0;
        check_eq("restart req", {31'd0, imem_if.req}, 32'd1);
        check_eq("restart addr", imem_if.addr, 32'h0);
        check_eq("restart instr nop", instr, NOP_INSTR);
        check_eq("restart valid", {31'd0, instr_valid}, 32'd0);

        // PC wrap at the top of the address space
        fetch_word("w0", 32'h0, 32'h6666_0001, 0);
        consume("jaltop", 1'b1, BR_JAL, 32'hFFFF_FFFC);
        fetch_word("wtop", 32'hFFFF_FFFC, 32'h6666_0002, 0);
        check_eq("wrap pc_plus4", pc_plus4, 32'h0);
        consume("wrap", 1'b0, BR_NONE, 32'd0);
        check_eq("wrap addr", imem_if.addr, 32'h0);
        check_eq("wrap req", {31'd0, imem_if.req}, 32'd1);
        check_eq("wrap misalign", {31'd0, misalign}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
